// File: rtl/nan_bist_ctrl.sv
// BIST sequencer: LFSR stimulus into a registered datapath,
// compares each returned bit against a fixed value, reports pass/fail.
module nan_bist_ctrl #(
  parameter int unsigned NUM_PAT  = 64,
  parameter int unsigned LAT      = 3,
  parameter logic [7:0]  SEED     = 8'hA5,
  parameter logic        EXP_RESP = 1'b1,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_in,
  output logic             stim_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  logic [7:0]       lfsr_q;
  logic [15:0]      pat_q;
  logic [LAT-1:0]   vld_q;

  logic [7:0]       lfsr_d;
  logic [ERR_W-1:0] err_d;
  logic             last_pat;

  // Next LFSR value, saturating mismatch count, last-issue detect
  always_comb begin
    lfsr_d   = {lfsr_q[6:0],
                lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    err_d    = err_cnt;
    if (vld_q[LAT-1] && (resp_in != EXP_RESP) && (err_cnt != '1))
      err_d = err_cnt + 1'b1;
    last_pat = (pat_q == 16'(NUM_PAT - 1));
  end

  // Sequencer FSM; the valid pipe tracks which edges carry a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      pat_q    <= '0;
      vld_q    <= '0;
      stim_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            pat_q   <= '0;
            lfsr_q  <= SEED;
            vld_q   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            stim_out <= 1'b0;
            vld_q    <= '0;
          end else begin
            stim_out <= lfsr_q[0];
            lfsr_q   <= lfsr_d;
            pat_q    <= pat_q + 16'd1;
            vld_q    <= LAT'({vld_q, 1'b1});
            err_cnt  <= err_d;
            if (last_pat)
              state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            stim_out <= 1'b0;
            vld_q    <= '0;
          end else begin
            stim_out <= 1'b0;
            vld_q    <= LAT'({vld_q, 1'b0});
            err_cnt  <= err_d;
            if (vld_q == '0) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_d == '0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nan_bist_ctrl.sv
// Bench for nan_bist_ctrl: vector table, directed corner runs,
// and randomized traffic against a timing-rule reference model.
module tb_nan_bist_ctrl;

  localparam int NP  = 8;
  localparam int LT  = 3;
  localparam int MAXE = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       resp = 1'b1;
  logic       stim, busy, done, pass;
  logic [7:0] err;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       resp2 = 1'b0;
  logic       stim2, busy2, done2, pass2;
  logic [1:0] err2;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // reference model state
  bit         m_act, m_done, m_pass, m_stim;
  int         m_err, m_k;
  logic [7:0] m_lfsr;
  int         dueq[$];

  always #5 clk = ~clk;

  nan_bist_ctrl #(
    .NUM_PAT(NP), .LAT(LT), .SEED(8'hA5),
    .EXP_RESP(1'b1), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .resp_in(resp), .stim_out(stim), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err)
  );

  nan_bist_ctrl #(
    .NUM_PAT(NP), .LAT(LT), .SEED(8'hA5),
    .EXP_RESP(1'b1), .ERR_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .resp_in(resp2), .stim_out(stim2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d act=%0h exp=%0h", nm, cycle, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic fb;
    fb = ^(l & 8'hB8);
    return {l[6:0], fb};
  endfunction

  // behaviour derived from the run's edge offset n = e - k
  task automatic model_step();
    int e, n;
    e = cycle;
    if (rst) begin
      m_act = 0; m_done = 0; m_pass = 0; m_stim = 0;
      m_err = 0; m_lfsr = 8'hA5; dueq.delete();
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_k = e; m_err = 0;
        m_done = 0; m_pass = 0; m_stim = 0;
        m_lfsr = 8'hA5; dueq.delete();
      end
    end else if (abort) begin
      m_act = 0; m_done = 0; m_pass = 0; m_stim = 0;
      dueq.delete();
    end else begin
      n = e - m_k;
      if (n >= 1 && n <= NP) begin
        m_stim = m_lfsr[0];
        m_lfsr = lfsr_step(m_lfsr);
        dueq.push_back(e + LT);
      end else begin
        m_stim = 0;
      end
      if (dueq.size() > 0 && dueq[0] == e) begin
        void'(dueq.pop_front());
        if (resp !== 1'b1 && m_err < MAXE) m_err++;
      end
      if (n == NP + LT + 1) begin
        m_act = 0; m_done = 1; m_pass = (m_err == 0);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cycle++;
    #1;
    chk("model", {busy, done, pass, stim, err},
        {m_act, m_done, m_pass, m_stim, 8'(m_err)});
  endtask

  typedef struct {
    logic       rst, start, resp;
    logic       stim, busy, done, pass;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[24];
  logic [7:0] seq;

  initial begin
    // stimuli 1,0,1,0,0,1,1,1 from A5; bit i = pattern i
    seq = 8'hE5;
    for (int i = 0; i < 24; i++) begin
      tbl[i].rst   = (i < 2);
      tbl[i].start = (i < 2) || (i == 10);
      tbl[i].resp  = 1'b1;
      tbl[i].stim  = (i >= 11 && i <= 18) ? seq[i-11] : 1'b0;
      tbl[i].busy  = (i >= 10 && i <= 21);
      tbl[i].done  = (i >= 22);
      tbl[i].pass  = (i >= 22);
      tbl[i].err   = 8'd0;
    end

    // reset with start held, then a clean run started at edge 10
    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; resp = tbl[i].resp;
      cyc();
      chk("tbl", {stim, busy, done, pass, err},
          {tbl[i].stim, tbl[i].busy, tbl[i].done,
           tbl[i].pass, tbl[i].err});
    end
    rst = 0; start = 0;

    // all-fail run
    start = 1; cyc(); start = 0; resp = 0;
    for (int j = 1; j <= 12; j++) cyc();
    resp = 1;
    chk("allfail_done", 32'(done), 32'd1);
    chk("allfail_err", 32'(err), 32'd8);
    chk("allfail_pass", 32'(pass), 32'd0);

    // saturation on a 2-bit counter
    start2 = 1; cyc(); start2 = 0;
    for (int j = 1; j <= 12; j++) cyc();
    chk("sat_done", 32'(done2), 32'd1);
    chk("sat_err", 32'(err2), 32'd3);
    chk("sat_pass", 32'(pass2), 32'd0);

    // single injected error; a start while busy is ignored
    start = 1; cyc(); start = 0;
    for (int j = 1; j <= 12; j++) begin
      resp  = (j == 1 + LT + 4) ? 1'b0 : 1'b1;
      start = (j == 5);
      cyc();
      if (j == 11) chk("inj_busy11", {busy, done}, 2'b10);
    end
    start = 0; resp = 1;
    chk("inj_done", 32'(done), 32'd1);
    chk("inj_err", 32'(err), 32'd1);
    chk("inj_pass", 32'(pass), 32'd0);

    // abort mid-run holds the partial count
    start = 1; cyc(); start = 0;
    for (int j = 1; j <= 5; j++) begin
      resp  = (j == 4) ? 1'b0 : 1'b1;
      abort = (j == 5);
      cyc();
    end
    abort = 0; resp = 1;
    chk("abort_st", {stim, busy, done, pass}, 4'b0000);
    chk("abort_err", 32'(err), 32'd1);
    start = 1; cyc(); start = 0;
    for (int j = 1; j <= 12; j++) cyc();
    chk("rerun", {busy, done, pass, err}, {3'b011, 8'd0});

    // reset while draining
    start = 1; cyc(); start = 0;
    for (int j = 1; j <= 10; j++) begin
      rst = (j == 10);
      if (j == 10) chk("drain_busy", 32'(busy), 32'd1);
      cyc();
    end
    rst = 0;
    chk("drain_rst", {stim, busy, done, pass, err}, 12'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(63) == 0);
      start = ($urandom_range(7) == 0);
      abort = ($urandom_range(23) == 0);
      resp  = ($urandom_range(7) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
